// File: rtl/spi_slave_reg_ctrl_pkg.sv
// Shared definitions for the SPI-slave-to-register-bus bridge.
package spi_slave_reg_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WR_DATA,
    RD_DATA,
    BUS_WR,
    BUS_RD
  } state_t;

  localparam int unsigned RW_BIT    = 7;
  localparam logic [7:0]  IDLE_FILL = 8'hFF;

endpackage

// File: rtl/spi_slave_reg_ctrl_tmo.sv
// Register-bus ack timeout counter: cleared on load, expires after LIMIT counted cycles.
module spi_slave_reg_ctrl_tmo #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_load,
  input  logic i_count,
  output logic o_expire
);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr || i_load) begin
      r_cnt <= '0;
    end else if (i_count) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // Fires on the LIMIT-th cycle the strobe has been high.
  assign o_expire = i_count && (r_cnt == 8'(LIMIT - 1));

endmodule

// File: rtl/spi_slave_reg_ctrl.sv
// Bridges SPI slave byte frames ({rw,addr} then data bytes) onto a simple register bus.
module spi_slave_reg_ctrl
  import spi_slave_reg_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              spi_rdy,
  output logic              spi_rdy_ack,
  input  logic [7:0]        spi_rx_data,
  input  logic              spi_first_byte,
  input  logic              spi_last_byte,
  output logic              spi_last_byte_ack,
  output logic [7:0]        spi_tx_data,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [7:0]        reg_rdata,
  input  logic              reg_ack,
  output logic              err
);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [7:0]        r_wdata, w_wdata_nxt;
  logic [7:0]        r_tx, w_tx_nxt;
  logic              r_wr, w_wr_nxt;
  logic              r_rd, w_rd_nxt;
  logic              r_rdy_ack, w_rdy_ack_nxt;
  logic              r_last_ack, w_last_ack_nxt;
  logic              r_rw, w_rw_nxt;
  logic              r_err, w_err_nxt;
  logic              w_rdy, w_last, w_strobe, w_done, w_load, w_expire;

  // The slave drops its level one cycle after our ack, so mask that cycle.
  assign w_rdy    = spi_rdy && !r_rdy_ack;
  assign w_last   = spi_last_byte && !r_last_ack;
  assign w_strobe = r_wr || r_rd;
  assign w_done   = w_strobe && (reg_ack || w_expire);

  spi_slave_reg_ctrl_tmo #(
    .LIMIT(ACK_TIMEOUT)
  ) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (!en),
    .i_load  (w_load),
    .i_count (w_strobe),
    .o_expire(w_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      r_state <= IDLE;
    else if (!en) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_tx_nxt       = r_tx;
    w_wr_nxt       = r_wr;
    w_rd_nxt       = r_rd;
    w_rdy_ack_nxt  = 1'b0;
    w_last_ack_nxt = 1'b0;
    w_rw_nxt       = r_rw;
    w_err_nxt      = r_err;
    w_load         = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rdy) begin
          w_rdy_ack_nxt = 1'b1;
          if (spi_first_byte) begin
            w_addr_nxt  = spi_rx_data[ADDR_W-1:0];
            w_rw_nxt    = spi_rx_data[RW_BIT];
            w_state_nxt = spi_rx_data[RW_BIT] ? BUS_RD : WR_DATA;
          end
        end else if (w_last) begin
          w_last_ack_nxt = 1'b1;
        end
      end
      CMD: begin
        if (w_last) begin
          w_last_ack_nxt = 1'b1;
          w_state_nxt    = IDLE;
        end else begin
          w_state_nxt = r_rw ? BUS_RD : WR_DATA;
        end
      end
      WR_DATA, RD_DATA: begin
        if (w_rdy) begin
          w_rdy_ack_nxt = 1'b1;
          if (spi_first_byte) begin
            // Mid-frame command: restart decode through CMD.
            w_addr_nxt  = spi_rx_data[ADDR_W-1:0];
            w_rw_nxt    = spi_rx_data[RW_BIT];
            w_state_nxt = CMD;
          end else if (r_state == WR_DATA) begin
            w_wdata_nxt = spi_rx_data;
            w_state_nxt = BUS_WR;
          end else begin
            w_state_nxt = BUS_RD;
          end
        end else if (w_last) begin
          w_last_ack_nxt = 1'b1;
          w_state_nxt    = IDLE;
        end
      end
      BUS_WR, BUS_RD: begin
        if (!w_strobe) begin
          w_wr_nxt = (r_state == BUS_WR);
          w_rd_nxt = (r_state == BUS_RD);
          w_load   = 1'b1;
        end else if (w_done) begin
          w_wr_nxt   = 1'b0;
          w_rd_nxt   = 1'b0;
          w_addr_nxt = r_addr + ADDR_W'(1);
          if (!reg_ack) w_err_nxt = 1'b1;
          if (r_state == BUS_RD) w_tx_nxt = reg_ack ? reg_rdata : IDLE_FILL;
          if (w_last) begin
            w_last_ack_nxt = 1'b1;
            w_state_nxt    = IDLE;
          end else begin
            w_state_nxt = (r_state == BUS_WR) ? WR_DATA : RD_DATA;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_tx       <= IDLE_FILL;
      r_wr       <= 1'b0;
      r_rd       <= 1'b0;
      r_rdy_ack  <= 1'b0;
      r_last_ack <= 1'b0;
      r_rw       <= 1'b0;
      r_err      <= 1'b0;
    end else if (!en) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_tx       <= IDLE_FILL;
      r_wr       <= 1'b0;
      r_rd       <= 1'b0;
      r_rdy_ack  <= 1'b0;
      r_last_ack <= 1'b0;
      r_rw       <= 1'b0;
    end else begin
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_tx       <= w_tx_nxt;
      r_wr       <= w_wr_nxt;
      r_rd       <= w_rd_nxt;
      r_rdy_ack  <= w_rdy_ack_nxt;
      r_last_ack <= w_last_ack_nxt;
      r_rw       <= w_rw_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign spi_rdy_ack       = r_rdy_ack;
  assign spi_last_byte_ack = r_last_ack;
  assign spi_tx_data       = r_tx;
  assign reg_addr          = r_addr;
  assign reg_wdata         = r_wdata;
  assign reg_wr            = r_wr;
  assign reg_rd            = r_rd;
  assign err               = r_err;

endmodule

// File: tb/tb_spi_slave_reg_ctrl.sv
// Scoreboard bench: expected bus accesses queued with stimulus, observed accesses drained per test.
module tb_spi_slave_reg_ctrl;

  typedef struct packed {
    logic       wr;
    logic       rd;
    logic [6:0] addr;
    logic [7:0] data;
  } bus_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic       spi_rdy = 1'b0;
  logic       spi_rdy_ack;
  logic [7:0] spi_rx_data = 8'h00;
  logic       spi_first_byte = 1'b0;
  logic       spi_last_byte = 1'b0;
  logic       spi_last_byte_ack;
  logic [7:0] spi_tx_data;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_rdata = 8'h00;
  logic       reg_ack = 1'b0;
  logic       err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int scnt = 0;
  int last_len = 0;
  int strobe_cyc = 0;
  int rdy_cyc = 0;
  int ack_delay = 1;
  bus_t exp_q[$];
  bus_t obs_q[$];

  spi_slave_reg_ctrl #(.ADDR_W(7), .ACK_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .en(en),
    .spi_rdy(spi_rdy), .spi_rdy_ack(spi_rdy_ack), .spi_rx_data(spi_rx_data),
    .spi_first_byte(spi_first_byte), .spi_last_byte(spi_last_byte),
    .spi_last_byte_ack(spi_last_byte_ack), .spi_tx_data(spi_tx_data),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_rdata(reg_rdata), .reg_ack(reg_ack), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [7:0] rd_model(input logic [6:0] a);
    return {a, 1'b1} ^ 8'h3C;
  endfunction

  // Register-bus responder and access monitor (ack_delay == 0 means never ack).
  always @(negedge clk) begin
    if (reg_wr || reg_rd) begin
      if (scnt == 0) begin
        obs_q.push_back({reg_wr, reg_rd, reg_addr, reg_wr ? reg_wdata : 8'h00});
        strobe_cyc = cyc;
      end
      scnt++;
      if (ack_delay != 0 && scnt == ack_delay) begin
        reg_ack   = 1'b1;
        reg_rdata = rd_model(reg_addr);
      end else begin
        reg_ack = 1'b0;
      end
    end else begin
      if (scnt != 0) last_len = scnt;
      scnt    = 0;
      reg_ack = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic f);
    bit got = 0;
    @(negedge clk);
    spi_rx_data = d; spi_first_byte = f; spi_rdy = 1'b1; rdy_cyc = cyc;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (spi_rdy_ack) got = 1;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL rdy_ack_wait byte=%h got=no_ack want=ack", d);
    end
    @(negedge clk);
    spi_rdy = 1'b0; spi_first_byte = 1'b0;
  endtask

  task automatic end_frame();
    bit got = 0;
    @(negedge clk);
    spi_last_byte = 1'b1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (spi_last_byte_ack) got = 1;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL last_ack_wait got=no_ack want=ack");
    end
    spi_last_byte = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (!reg_wr && !reg_rd) ok = 1;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL strobe_wait got=busy want=idle");
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [27:0] got;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    got = {spi_tx_data, reg_addr, reg_wdata, reg_wr, reg_rd, spi_rdy_ack, spi_last_byte_ack, err};
    total++;
    if (got !== {8'hFF, 7'h00, 8'h00, 5'b00000}) begin
      bad++; $display("FAIL reset_state got=%h want=%h", got, {8'hFF, 7'h00, 8'h00, 5'b00000});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    bus_t e, o;
    exp_q.push_back({1'b1, 1'b0, 7'h05, 8'hA1});
    exp_q.push_back({1'b1, 1'b0, 7'h06, 8'hB2});
    send_byte(8'h05, 1'b1);
    send_byte(8'hA1, 1'b0);
    wait_idle();
    total++;
    if (strobe_cyc - rdy_cyc !== 2) begin
      bad++; $display("FAIL wr_latency got=%0d want=2", strobe_cyc - rdy_cyc);
    end
    send_byte(8'hB2, 1'b0);
    end_frame();
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      e = 'x; o = 'x;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL write_bus got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_read();
    bus_t e, o;
    exp_q.push_back({1'b0, 1'b1, 7'h03, 8'h00});
    exp_q.push_back({1'b0, 1'b1, 7'h04, 8'h00});
    exp_q.push_back({1'b0, 1'b1, 7'h05, 8'h00});
    send_byte(8'h83, 1'b1);
    wait_idle();
    total++;
    if (spi_tx_data !== rd_model(7'h03)) begin
      bad++; $display("FAIL read_prefetch0 got=%h want=%h", spi_tx_data, rd_model(7'h03));
    end
    send_byte(8'hEE, 1'b0);
    wait_idle();
    total++;
    if (spi_tx_data !== rd_model(7'h04)) begin
      bad++; $display("FAIL read_prefetch1 got=%h want=%h", spi_tx_data, rd_model(7'h04));
    end
    send_byte(8'hEE, 1'b0);
    wait_idle();
    total++;
    if (spi_tx_data !== rd_model(7'h05)) begin
      bad++; $display("FAIL read_prefetch2 got=%h want=%h", spi_tx_data, rd_model(7'h05));
    end
    end_frame();
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      e = 'x; o = 'x;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL read_bus got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_wrap();
    bus_t e, o;
    exp_q.push_back({1'b1, 1'b0, 7'h7F, 8'h11});
    exp_q.push_back({1'b1, 1'b0, 7'h00, 8'h22});
    send_byte(8'h7F, 1'b1);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    end_frame();
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      e = 'x; o = 'x;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL wrap_bus got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_last_during_bus();
    bus_t e, o;
    bit got = 0;
    ack_delay = 3;
    exp_q.push_back({1'b1, 1'b0, 7'h20, 8'h5A});
    send_byte(8'h20, 1'b1);
    send_byte(8'h5A, 1'b0);
    spi_last_byte = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (spi_last_byte_ack) got = 1;
    end
    spi_last_byte = 1'b0;
    total++;
    if (!got || reg_wr !== 1'b0) begin
      bad++; $display("FAIL last_in_bus got=ack%0d/wr%b want=ack1/wr0", got, reg_wr);
    end
    @(negedge clk);
    total++;
    if (last_len !== 3 || spi_last_byte_ack !== 1'b0) begin
      bad++; $display("FAIL last_in_bus_len got=%0d/%b want=3/0", last_len, spi_last_byte_ack);
    end
    ack_delay = 1;
    send_byte(8'h77, 1'b0);
    repeat (4) @(negedge clk);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      e = 'x; o = 'x;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL last_bus got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_resync();
    bus_t e, o;
    exp_q.push_back({1'b1, 1'b0, 7'h30, 8'h01});
    exp_q.push_back({1'b0, 1'b1, 7'h04, 8'h00});
    send_byte(8'h30, 1'b1);
    send_byte(8'h01, 1'b0);
    wait_idle();
    send_byte(8'h84, 1'b1);
    wait_idle();
    total++;
    if (spi_tx_data !== rd_model(7'h04)) begin
      bad++; $display("FAIL resync_tx got=%h want=%h", spi_tx_data, rd_model(7'h04));
    end
    end_frame();
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      e = 'x; o = 'x;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL resync_bus got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_timeout();
    bus_t e, o;
    ack_delay = 0;
    exp_q.push_back({1'b0, 1'b1, 7'h10, 8'h00});
    send_byte(8'h90, 1'b1);
    wait_idle();
    total++;
    if (last_len !== 15 || spi_tx_data !== 8'hFF || err !== 1'b1) begin
      bad++; $display("FAIL timeout got=len%0d/tx%h/err%b want=len15/txff/err1", last_len, spi_tx_data, err);
    end
    end_frame();
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      e = 'x; o = 'x;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL timeout_bus got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_enable();
    bus_t e, o;
    exp_q.push_back({1'b0, 1'b1, 7'h20, 8'h00});
    send_byte(8'hA0, 1'b1);
    repeat (2) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    total++;
    if ({reg_rd, err, spi_tx_data, reg_addr} !== {1'b0, 1'b1, 8'hFF, 7'h00}) begin
      bad++; $display("FAIL enable_low got=%h want=%h", {reg_rd, err, spi_tx_data, reg_addr}, {1'b0, 1'b1, 8'hFF, 7'h00});
    end
    en = 1'b1;
    repeat (2) @(negedge clk);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      e = 'x; o = 'x;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL enable_bus got=%h want=%h", o, e); end
    end
  endtask

  task automatic test_rst_mid_read();
    bus_t e, o;
    logic [27:0] got;
    exp_q.push_back({1'b0, 1'b1, 7'h40, 8'h00});
    send_byte(8'hC0, 1'b1);
    @(negedge clk);
    total++;
    if (reg_rd !== 1'b1 || err !== 1'b1) begin
      bad++; $display("FAIL pre_rst got=rd%b/err%b want=rd1/err1", reg_rd, err);
    end
    #2 rst = 1'b1;
    #1;
    got = {spi_tx_data, reg_addr, reg_wdata, reg_wr, reg_rd, spi_rdy_ack, spi_last_byte_ack, err};
    total++;
    if (got !== {8'hFF, 7'h00, 8'h00, 5'b00000}) begin
      bad++; $display("FAIL rst_async got=%h want=%h", got, {8'hFF, 7'h00, 8'h00, 5'b00000});
    end
    @(negedge clk);
    rst = 1'b0;
    ack_delay = 1;
    repeat (3) @(negedge clk);
    while (exp_q.size() > 0 || obs_q.size() > 0) begin
      e = 'x; o = 'x;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL rst_bus got=%h want=%h", o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_last_during_bus();
    test_resync();
    test_timeout();
    test_enable();
    test_rst_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
